// File: rtl/logic_pkg.sv
// rtl/logic_pkg.sv - shared opcodes, width and state encoding for the logic-op arbiter
// Contents: OP_* opcode constants, WIDTH_W datapath width, state_e slot state.
package logic_pkg;

    localparam int WIDTH_W = 16;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    // Result slot: EMPTY holds nothing, FULL presents rsp_valid=1.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/logic16.sv
// rtl/logic16.sv - combinational 16-bit bitwise unit (NOT/AND/OR/XOR)
// Ports:
//   op : operation code (OP_NOT, OP_AND, OP_OR, OP_XOR)
//   a  : operand a
//   b  : operand b, ignored for OP_NOT
//   y  : result
module logic16
    import logic_pkg::*;
(
    input  logic [1:0]         op,
    input  logic [WIDTH_W-1:0] a,
    input  logic [WIDTH_W-1:0] b,
    output logic [WIDTH_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// rtl/logic_op_arbiter.sv - round-robin arbiter sharing one logic16 between two requesters
// Optional feature macro: LOGIC_OP_ARBITER_STATS_EN (per-requester grant counters).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   reqN_valid/ready           : request handshake for requester N (ready is combinational)
//   reqN_op, reqN_a, reqN_b    : operation and operands for requester N
//   rsp_valid/ready            : response handshake, result held until accepted
//   rsp_data, rsp_id           : registered result and the requester that issued it
//   stats_clr                  : (STATS_EN) synchronous clear of both grant counters
//   grant0_cnt, grant1_cnt     : (STATS_EN) saturating grant counts per requester
module logic_op_arbiter
    import logic_pkg::*;
#(
    parameter int WIDTH = WIDTH_W
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
`ifdef LOGIC_OP_ARBITER_STATS_EN
    input  logic             stats_clr,
    output logic [15:0]      grant0_cnt,
    output logic [15:0]      grant1_cnt,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id
);

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             id_q, id_d;

    logic             free;
    logic             grant0, grant1;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b, alu_y;

    assign rsp_valid = (state_q == FULL);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;

    // Slot can take a new result when empty or when the held one leaves this cycle.
    assign free = (state_q == EMPTY) | (rsp_valid & rsp_ready);

    // rst_n gating keeps both readies low while reset is held, since the
    // cleared state alone would otherwise look like a free slot.
    assign grant0 = rst_n & free & req0_valid & (~req1_valid | ~rr_q);
    assign grant1 = rst_n & free & req1_valid & (~req0_valid |  rr_q);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign sel_op = grant1 ? req1_op : req0_op;
    assign sel_a  = grant1 ? req1_a  : req0_a;
    assign sel_b  = grant1 ? req1_b  : req0_b;

    logic16 u_logic16 (
        .op (sel_op),
        .a  (sel_a),
        .b  (sel_b),
        .y  (alu_y)
    );

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        data_d  = data_q;
        id_d    = id_q;
        if (grant0 | grant1) begin
            state_d = FULL;
            data_d  = alu_y;
            id_d    = grant1;
            rr_d    = ~grant1;  // the requester just served loses the next tie
        end else if (rsp_valid & rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            rr_q    <= 1'b0;
            data_q  <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

`ifdef LOGIC_OP_ARBITER_STATS_EN
    logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    assign grant0_cnt = cnt0_q;
    assign grant1_cnt = cnt1_q;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (stats_clr) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else begin
            if (grant0 && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
            if (grant1 && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb/tb_logic_op_arbiter.sv - self-checking bench for logic_op_arbiter
module tb_logic_op_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [1:0]  req0_op;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [1:0]  req1_op;
    logic [15:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_id;
`ifdef LOGIC_OP_ARBITER_STATS_EN
    logic        stats_clr;
    logic [15:0] grant0_cnt, grant1_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic_op_arbiter #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
`ifdef LOGIC_OP_ARBITER_STATS_EN
        .stats_clr  (stats_clr),
        .grant0_cnt (grant0_cnt),
        .grant1_cnt (grant1_cnt),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'd0:    return ~a;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_drain();
        req0_valid = 0;
        req1_valid = 0;
        rsp_ready  = 1;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 0;
        req0_valid = 1; req0_op = 2'd0; req0_a = 16'h1111; req0_b = 0;
        req1_valid = 1; req1_op = 2'd1; req1_a = 16'h2222; req1_b = 0;
        rsp_ready = 1;
`ifdef LOGIC_OP_ARBITER_STATS_EN
        stats_clr = 0;
`endif
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got %h exp 0000", rsp_data); end
        checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %b exp 0", rsp_id); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_readies got %b exp 00", {req0_ready, req1_ready}); end
`ifdef LOGIC_OP_ARBITER_STATS_EN
        checks++; if ({grant0_cnt, grant1_cnt} !== 32'h0) begin errors++; $display("FAIL reset_counts got %h exp 0", {grant0_cnt, grant1_cnt}); end
`endif
        req0_valid = 0;
        req1_valid = 0;
        next_cycle();
        rst_n = 1;
        next_cycle();
    endtask

    task automatic test_contention();
        req0_valid = 1; req0_op = 2'd1; req0_a = 16'hF0F0; req0_b = 16'hFF00;
        req1_valid = 1; req1_op = 2'd3; req1_a = 16'hAAAA; req1_b = 16'hFFFF;
        rsp_ready = 1;
        @(negedge clk);
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL contention_grant1 got %b exp 10", {req0_ready, req1_ready}); end
        next_cycle();
        req0_valid = 0;
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 16'hF000}) begin errors++; $display("FAIL contention_rsp0 got %b/%b/%h exp 1/0/f000", rsp_valid, rsp_id, rsp_data); end
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL contention_grant2 got %b exp 1", req1_ready); end
        next_cycle();
        req1_valid = 0;
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 16'h5555}) begin errors++; $display("FAIL contention_rsp1 got %b/%b/%h exp 1/1/5555", rsp_valid, rsp_id, rsp_data); end
        idle_drain();
    endtask

    task automatic test_single_op();
        req0_valid = 1; req0_op = 2'd0; req0_a = 16'h00FF; req0_b = 16'h1234;
        rsp_ready = 1;
        @(negedge clk);
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got %b exp 10", {req0_ready, req1_ready}); end
        next_cycle();
        req0_valid = 0;
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 16'hFF00}) begin errors++; $display("FAIL single_rsp got %b/%b/%h exp 1/0/ff00", rsp_valid, rsp_id, rsp_data); end
        next_cycle();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", rsp_valid); end
        idle_drain();
    endtask

    // Entered with requester 1 preferred on a tie (last grant went to 0).
    task automatic test_backpressure();
        rsp_ready = 0;
        req0_valid = 1; req0_op = 2'd2; req0_a = 16'h1230; req0_b = 16'h0004;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_first_grant got %b exp 1", req0_ready); end
        next_cycle();
        req0_op = 2'd3; req0_a = 16'h0F0F; req0_b = 16'h00FF;
        req1_valid = 1; req1_op = 2'd1; req1_a = 16'hFFFF; req1_b = 16'hABCD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 16'h1234}) begin errors++; $display("FAIL bp_hold%0d got %b/%b/%h exp 1/0/1234", i, rsp_valid, rsp_id, rsp_data); end
            checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got %b exp 00", i, {req0_ready, req1_ready}); end
            next_cycle();
        end
        rsp_ready = 1;
        @(negedge clk);
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL bp_release_grant got %b exp 01", {req0_ready, req1_ready}); end
        next_cycle();
        req1_valid = 0;
        req0_valid = 0;
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 16'hABCD}) begin errors++; $display("FAIL bp_next_rsp got %b/%b/%h exp 1/1/abcd", rsp_valid, rsp_id, rsp_data); end
        idle_drain();
    endtask

    // Entered with requester 0 preferred on a tie (last grant went to 1).
    task automatic test_fairness();
        logic [7:0] seq;
`ifdef LOGIC_OP_ARBITER_STATS_EN
        stats_clr = 1;
        next_cycle();
        stats_clr = 0;
`endif
        rsp_ready = 1;
        req0_valid = 1; req0_op = 2'd1; req0_a = 16'h00FF; req0_b = 16'h0F0F;
        req1_valid = 1; req1_op = 2'd2; req1_a = 16'hF000; req1_b = 16'h000F;
        seq = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if ((req0_ready ^ req1_ready) !== 1'b1) begin errors++; $display("FAIL fair_onehot%0d got %b%b exp one ready", i, req0_ready, req1_ready); end
            seq[i] = req1_ready;
            if (i > 0) begin
                checks++; if ({rsp_valid, rsp_id} !== {1'b1, seq[i-1]}) begin errors++; $display("FAIL fair_rsp%0d got %b/%b exp 1/%b", i, rsp_valid, rsp_id, seq[i-1]); end
            end
            next_cycle();
        end
        req0_valid = 0;
        req1_valid = 0;
        checks++; if (seq !== 8'b1010_1010) begin errors++; $display("FAIL fair_sequence got %b exp 10101010", seq); end
`ifdef LOGIC_OP_ARBITER_STATS_EN
        @(negedge clk);
        checks++; if ({grant0_cnt, grant1_cnt} !== {16'd4, 16'd4}) begin errors++; $display("FAIL fair_counts got %0d/%0d exp 4/4", grant0_cnt, grant1_cnt); end
        next_cycle();
        stats_clr = 1;
        next_cycle();
        stats_clr = 0;
        @(negedge clk);
        checks++; if ({grant0_cnt, grant1_cnt} !== 32'h0) begin errors++; $display("FAIL stats_clr got %0d/%0d exp 0/0", grant0_cnt, grant1_cnt); end
`endif
        idle_drain();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 0;
        req0_valid = 1; req0_op = 2'd0; req0_a = 16'h0000; req0_b = 16'h0000;
        next_cycle();
        req0_valid = 0;
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_data} !== {1'b1, 16'hFFFF}) begin errors++; $display("FAIL mid_before got %b/%h exp 1/ffff", rsp_valid, rsp_data); end
        rst_n = 0;
        #1;
        checks++; if ({rsp_valid, rsp_data, rsp_id} !== {1'b0, 16'h0000, 1'b0}) begin errors++; $display("FAIL mid_async_clear got %b/%h/%b exp 0/0000/0", rsp_valid, rsp_data, rsp_id); end
        next_cycle();
        rst_n = 1;
        rsp_ready = 1;
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL mid_rr_reset got %b exp 10", {req0_ready, req1_ready}); end
        next_cycle();
        idle_drain();
    endtask

    task automatic test_random();
        logic        m_full, m_id, m_pref, e0, e1, free;
        logic [15:0] m_data;
        rst_n = 0;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        next_cycle();
        rst_n = 1;
        m_full = 0; m_id = 0; m_data = 0; m_pref = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            free = !m_full || rsp_ready;
            e0 = free && req0_valid && (!req1_valid || m_pref == 1'b0);
            e1 = free && req1_valid && (!req0_valid || m_pref == 1'b1);
            checks++; if ({req0_ready, req1_ready} !== {e0, e1}) begin errors++; $display("FAIL rnd_ready c%0d got %b%b exp %b%b", c, req0_ready, req1_ready, e0, e1); end
            checks++; if (rsp_valid !== m_full) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, rsp_valid, m_full); end
            if (m_full) begin
                checks++; if ({rsp_id, rsp_data} !== {m_id, m_data}) begin errors++; $display("FAIL rnd_rsp c%0d got %b/%h exp %b/%h", c, rsp_id, rsp_data, m_id, m_data); end
            end
            if (e0) begin
                m_full = 1; m_id = 0; m_data = ref_op(req0_op, req0_a, req0_b); m_pref = 1;
            end else if (e1) begin
                m_full = 1; m_id = 1; m_data = ref_op(req1_op, req1_a, req1_b); m_pref = 0;
            end else if (m_full && rsp_ready) begin
                m_full = 0;
            end
            next_cycle();
            // A waiting request keeps its payload; only a fresh one is re-drawn.
            if (!req0_valid || e0) begin
                req0_valid = ($urandom % 4) != 0;
                req0_op = 2'($urandom); req0_a = 16'($urandom); req0_b = 16'($urandom);
            end
            if (!req1_valid || e1) begin
                req1_valid = ($urandom % 4) != 0;
                req1_op = 2'($urandom); req1_a = 16'($urandom); req1_b = 16'($urandom);
            end
            rsp_ready = ($urandom % 3) != 0;
        end
        idle_drain();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_op();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
